reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 4, giving the number of downstream reset domains (legal range 1..8).
REQ-002 The block SHALL have parameter DELAY_CYCLES, default 1000, giving the clk_c0 cycles of post-lock settling delay (legal range >=1).
REQ-003 The block SHALL have parameter LOCK_FILTER, default 16, giving the consecutive clk_c0 cycles pll_locked must stay high to count as stable.
REQ-004 The block SHALL have parameter STAGGER, default 4, giving the clk_c0 cycles between successive domain releases.
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (legal range 2..4).
REQ-006 The block SHALL have input clk_c0, 1 bit: sequencer clock.
REQ-007 The block SHALL have input rst_n, 1 bit: reset, asynchronous, active-low; the sequencer runs on clock clk_c0.
REQ-008 The block SHALL have input pll_locked, 1 bit: PLL lock, asynchronous to clk_c0.
REQ-009 The block SHALL have input soft_rst_req, 1 bit: single-cycle soft reset request, synchronous to clk_c0.
REQ-010 The block SHALL have input dom_clk, NUM_DOMAINS bits: per-domain clocks.
REQ-011 The block SHALL have output sys_rst_n, 1 bit: active-low reset in the clk_c0 domain.
REQ-012 The block SHALL have output dom_rst_n, NUM_DOMAINS bits: per-domain active-low resets, with bit i synchronous to dom_clk[i].
REQ-013 The block SHALL have output state, 3 bits: current FSM state code.
REQ-014 The block SHALL have output lock_lost_cnt, 8 bits: saturating count of lock-loss events.

Function
REQ-015 pll_locked SHALL be sampled through a SYNC_STAGES flop chain on clk_c0; lock_s denotes the chain output.
REQ-016 FSM state codes SHALL be WAIT_LOCK=0, FILTER=1, DELAY=2, RELEASE=3, RUN=4; codes 5-7 SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL go to FILTER when lock_s=1, and SHALL clear the shared counter.
REQ-018 FILTER SHALL count cycles with lock_s=1.
  - On reaching LOCK_FILTER, it SHALL go to DELAY and clear the counter.
  - If lock_s=0, it SHALL go to WAIT_LOCK and the count SHALL restart from 0.
REQ-019 DELAY SHALL count DELAY_CYCLES cycles, then go to RELEASE with the counter cleared.
REQ-020 sys_rst_n SHALL be registered high on the clk_c0 edge that enters RELEASE.
REQ-021 The internal release bit rel[i] SHALL be set when the RELEASE counter equals STAGGER*i, with rel[0] set on RELEASE entry.
REQ-022 RELEASE SHALL go to RUN one cycle after rel[NUM_DOMAINS-1] is set.
REQ-023 With pll_locked held high, sys_rst_n SHALL rise exactly SYNC_STAGES+LOCK_FILTER+DELAY_CYCLES+1 clk_c0 edges after the first edge sampling pll_locked=1.
REQ-024 If lock_s=0 in DELAY, RELEASE or RUN, the next state SHALL be WAIT_LOCK.
  - On that same edge, sys_rst_n=0 and all rel bits SHALL be cleared.
  - lock_lost_cnt SHALL increment, saturating at 255.
REQ-025 soft_rst_req=1 in RELEASE or RUN with lock_s=1 SHALL go to DELAY, skipping FILTER.
  - sys_rst_n=0 and all rel bits SHALL be cleared; lock_lost_cnt SHALL be unchanged.
REQ-026 soft_rst_req SHALL be ignored in WAIT_LOCK, FILTER and DELAY.
REQ-027 Lock loss SHALL take priority over a simultaneous soft_rst_req.
REQ-028 dom_rst_n[i] SHALL be a SYNC_STAGES flop chain clocked by dom_clk[i], shifting in 1, with its flops asynchronously cleared by (!rst_n | !rel[i]).
  - Assertion SHALL be asynchronous.
  - Deassertion SHALL occur SYNC_STAGES dom_clk[i] edges after rel[i] rises.
REQ-029 The counter SHALL be sized to hold max(DELAY_CYCLES, LOCK_FILTER, STAGGER*(NUM_DOMAINS-1)+1) and SHALL never wrap.
REQ-030 A dom_clk[i] that is stopped SHALL NOT stall the FSM; only that domain's deassertion is delayed.

Reset
REQ-031 While rst_n=0, the block SHALL hold: state=WAIT_LOCK, counter=0, lock_s chain=0, sys_rst_n=0, rel=0, dom_rst_n=0 (asynchronous), lock_lost_cnt=0.
REQ-032 A rst_n assertion mid-sequence SHALL abort immediately to the REQ-031 values.
REQ-033 The sequence SHALL restart from WAIT_LOCK after rst_n deasserts.

Verification (NUM_DOMAINS=3, DELAY_CYCLES=20, LOCK_FILTER=4, STAGGER=2, SYNC_STAGES=2)
REQ-034 Cold start: rst_n released, pll_locked rises -> sys_rst_n rises at edge 27, state passes 0,1,2,3,4, and dom_rst_n[0..2] rise 2 dom_clk edges after edges 27/29/31 respectively.
REQ-035 Lock glitch: pll_locked high 3 cycles then low during FILTER -> state returns to 0, no release occurs, lock_lost_cnt stays 0.
REQ-036 Lock loss in RUN: pll_locked drops -> sys_rst_n=0 and dom_rst_n=0 within SYNC_STAGES+1 clk_c0 edges, lock_lost_cnt=1; after relock the full sequence repeats.
REQ-037 Soft reset in RUN: 1-cycle soft_rst_req -> state=2 next edge, sys_rst_n low for 20 cycles, then staggered re-release; a simultaneous lock drop yields state=0 and lock_lost_cnt+1.
REQ-038 Saturation and async reset: 300 lock-loss events -> lock_lost_cnt=255; rst_n pulsed low mid-DELAY with dom_clk stopped -> all outputs 0 immediately.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for a stable PLL lock, holds a settling delay, then releases
// sys_rst_n and staggers per-domain resets, each synchronized into its own clock.
module reset_sequencer #(
   parameter int NUM_DOMAINS  = 4,
   parameter int DELAY_CYCLES = 1000,
   parameter int LOCK_FILTER  = 16,
   parameter int STAGGER      = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                   clk_c0,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   soft_rst_req,
   input  logic [NUM_DOMAINS-1:0] dom_clk,
   output logic                   sys_rst_n,
   output logic [NUM_DOMAINS-1:0] dom_rst_n,
   output logic [2:0]             state,
   output logic [7:0]             lock_lost_cnt
);
   localparam logic [2:0] WAIT_LOCK = 3'd0;
   localparam logic [2:0] FILTER    = 3'd1;
   localparam logic [2:0] DELAY     = 3'd2;
   localparam logic [2:0] RELEASE   = 3'd3;
   localparam logic [2:0] RUN       = 3'd4;
   localparam int REL_MAX = STAGGER * (NUM_DOMAINS - 1) + 1;
   localparam int MAX_A   = DELAY_CYCLES > LOCK_FILTER ? DELAY_CYCLES : LOCK_FILTER;
   localparam int CNT_MAX = MAX_A > REL_MAX ? MAX_A : REL_MAX;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER);
   localparam logic [CW-1:0] DC_LAST = CW'(DELAY_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [2:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
   logic [NUM_DOMAINS-1:0] rel_q, rel_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic [7:0]             lock_lost_cnt_q, lock_lost_cnt_d;
   logic                   lock_s;

   assign sync_d        = {sync_q[SYNC_STAGES-2:0], pll_locked};
   assign lock_s        = sync_q[SYNC_STAGES-1];
   assign cnt_inc       = cnt_q + CW'(1);
   assign sys_rst_n     = sys_rst_n_q;
   assign state         = state_q;
   assign lock_lost_cnt = lock_lost_cnt_q;

   always_comb begin
      state_d         = WAIT_LOCK;
      cnt_d           = '0;
      rel_d           = '0;
      lock_lost_cnt_d = lock_lost_cnt_q;
      case (state_q)
         WAIT_LOCK: state_d = lock_s ? FILTER : WAIT_LOCK;
         FILTER: if (lock_s) begin
            state_d = (cnt_inc == LF_LAST) ? DELAY : FILTER;
            cnt_d   = (cnt_inc == LF_LAST) ? '0 : cnt_inc;
         end
         DELAY: if (lock_s) begin
            state_d = (cnt_inc == DC_LAST) ? RELEASE : DELAY;
            cnt_d   = (cnt_inc == DC_LAST) ? '0 : cnt_inc;
         end
         RELEASE, RUN: if (lock_s) begin
            state_d = soft_rst_req ? DELAY :
                      (state_q == RUN || rel_q[NUM_DOMAINS-1]) ? RUN : RELEASE;
            cnt_d   = (state_d == RELEASE) ? cnt_inc : '0;
            rel_d   = soft_rst_req ? '0 : rel_q;
         end
         default: state_d = WAIT_LOCK;
      endcase
      // Lock loss after the filter is counted; a glitch during FILTER is not.
      if (!lock_s && (state_q == DELAY || state_q == RELEASE || state_q == RUN) && lock_lost_cnt_q != 8'hff)
         lock_lost_cnt_d = lock_lost_cnt_q + 8'd1;
      if (state_d == RELEASE)
         for (int i = 0; i < NUM_DOMAINS; i++)
            if (cnt_d == CW'(STAGGER * i)) rel_d[i] = 1'b1;
      sys_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
   end

   always_ff @(posedge clk_c0 or negedge rst_n)
      if (!rst_n) begin
         sync_q          <= '0;
         state_q         <= WAIT_LOCK;
         cnt_q           <= '0;
         rel_q           <= '0;
         sys_rst_n_q     <= 1'b0;
         lock_lost_cnt_q <= '0;
      end else begin
         sync_q          <= sync_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rel_q           <= rel_d;
         sys_rst_n_q     <= sys_rst_n_d;
         lock_lost_cnt_q <= lock_lost_cnt_d;
      end

   // Each domain asserts asynchronously and deasserts through its own clock; a stopped clock only delays that domain.
   for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
      logic [SYNC_STAGES-1:0] chain_q, chain_d;
      logic                   clr_n;
      assign clr_n = rst_n & rel_q[d];
      always_comb chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
      always_ff @(posedge dom_clk[d] or negedge clr_n)
         if (!clr_n) chain_q <= '0;
         else chain_q <= chain_d;
      assign dom_rst_n[d] = chain_q[SYNC_STAGES-1];
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vectors for reset_sequencer with hand-computed edge timing.
module tb_reset_sequencer;
   logic       clk_c0 = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic [2:0] dom_clk = '0;
   logic       sys_rst_n;
   logic [2:0] dom_rst_n;
   logic [2:0] state;
   logic [7:0] lock_lost_cnt;
   int n_chk = 0;
   int n_pass = 0;

   reset_sequencer #(
      .NUM_DOMAINS(3), .DELAY_CYCLES(20), .LOCK_FILTER(4), .STAGGER(2), .SYNC_STAGES(2)
   ) dut (
      .clk_c0(clk_c0), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
      .dom_clk(dom_clk), .sys_rst_n(sys_rst_n), .dom_rst_n(dom_rst_n), .state(state),
      .lock_lost_cnt(lock_lost_cnt)
   );

   always #5 clk_c0 = ~clk_c0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_c0);
      #1;
   endtask

   task automatic dpulse(input int n);
      repeat (n) begin
         dom_clk = '1;
         #1;
         dom_clk = '0;
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_sys", sys_rst_n, 0);
      chk("rst_dom", dom_rst_n, 0);
      chk("rst_lost", lock_lost_cnt, 0);
      rst_n = 1'b1;
      tick(3);
      chk("idle_state", state, 0);
      // Cold start: edge 1 is the first edge sampling pll_locked=1.
      pll_locked = 1'b1;
      tick(2);
      chk("cs_e2_state", state, 0);
      tick(1);
      chk("cs_e3_state", state, 1);
      tick(3);
      chk("cs_e6_state", state, 1);
      tick(1);
      chk("cs_e7_state", state, 2);
      tick(19);
      chk("cs_e26_sys", sys_rst_n, 0);
      chk("cs_e26_state", state, 2);
      tick(1);
      chk("cs_e27_sys", sys_rst_n, 1);
      chk("cs_e27_state", state, 3);
      chk("cs_e27_dom", dom_rst_n, 0);
      dpulse(1);
      chk("cs_dom0_1edge", dom_rst_n, 0);
      dpulse(1);
      chk("cs_dom0_2edge", dom_rst_n, 3'b001);
      tick(2);
      chk("cs_e29_state", state, 3);
      dpulse(2);
      chk("cs_dom1", dom_rst_n, 3'b011);
      tick(2);
      dpulse(1);
      chk("cs_dom2_1edge", dom_rst_n, 3'b011);
      dpulse(1);
      chk("cs_dom2_2edge", dom_rst_n, 3'b111);
      chk("cs_e31_state", state, 3);
      tick(1);
      chk("cs_e32_state", state, 4);
      // Lock loss in RUN
      pll_locked = 1'b0;
      tick(2);
      chk("ll_e2_sys", sys_rst_n, 1);
      tick(1);
      chk("ll_e3_sys", sys_rst_n, 0);
      chk("ll_e3_state", state, 0);
      chk("ll_e3_dom", dom_rst_n, 0);
      chk("ll_lost", lock_lost_cnt, 1);
      // Lock glitch during FILTER
      pll_locked = 1'b1;
      tick(3);
      chk("gl_filter", state, 1);
      pll_locked = 1'b0;
      tick(3);
      chk("gl_back", state, 0);
      tick(30);
      chk("gl_sys", sys_rst_n, 0);
      chk("gl_state", state, 0);
      chk("gl_lost", lock_lost_cnt, 1);
      // Relock repeats the full sequence
      pll_locked = 1'b1;
      tick(26);
      chk("rl_e26_sys", sys_rst_n, 0);
      tick(1);
      chk("rl_e27_sys", sys_rst_n, 1);
      tick(5);
      chk("rl_run", state, 4);
      dpulse(2);
      chk("rl_dom", dom_rst_n, 3'b111);
      // Soft reset in RUN, with a soft request during DELAY that must be ignored
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      chk("sr_state", state, 2);
      chk("sr_sys", sys_rst_n, 0);
      chk("sr_dom", dom_rst_n, 0);
      chk("sr_lost", lock_lost_cnt, 1);
      tick(9);
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      chk("sr_ignored", state, 2);
      tick(9);
      chk("sr_e19_sys", sys_rst_n, 0);
      tick(1);
      chk("sr_e20_sys", sys_rst_n, 1);
      chk("sr_e20_state", state, 3);
      tick(2);
      dpulse(2);
      chk("sr_stagger", dom_rst_n, 3'b011);
      tick(3);
      chk("sr_run", state, 4);
      dpulse(2);
      chk("sr_dom_all", dom_rst_n, 3'b111);
      // Lock loss wins over a simultaneous soft request
      pll_locked = 1'b0;
      tick(2);
      chk("pri_pre", state, 4);
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      chk("pri_state", state, 0);
      chk("pri_lost", lock_lost_cnt, 2);
      chk("pri_sys", sys_rst_n, 0);
      // Saturation: 300 lock losses while in DELAY
      for (int k = 0; k < 300; k++) begin
         pll_locked = 1'b1;
         tick(8);
         pll_locked = 1'b0;
         tick(3);
         if (k == 99) chk("sat_100", lock_lost_cnt, 102);
      end
      chk("sat_255", lock_lost_cnt, 255);
      chk("sat_state", state, 0);
      // Async reset mid-DELAY with dom_clk stopped
      pll_locked = 1'b1;
      tick(10);
      chk("ar_delay", state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_state", state, 0);
      chk("ar_sys", sys_rst_n, 0);
      chk("ar_dom", dom_rst_n, 0);
      chk("ar_lost", lock_lost_cnt, 0);
      rst_n = 1'b1;
      tick(26);
      chk("ar_e26_sys", sys_rst_n, 0);
      tick(1);
      chk("ar_e27_sys", sys_rst_n, 1);
      tick(5);
      chk("stop_run", state, 4);
      chk("stop_dom", dom_rst_n, 0);
      dpulse(2);
      chk("stop_dom_resume", dom_rst_n, 3'b111);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar2_dom", dom_rst_n, 0);
      chk("ar2_sys", sys_rst_n, 0);
      chk("ar2_state", state, 0);
      rst_n = 1'b1;
      tick(1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
